dmem_hs: RTL and testbench

- Parametrised data memory for the MIPS datapath.
- Adds over the earlier fixed 4-entry memory:
  - a valid/ready request handshake;
  - byte/half/word access with sign extension;
  - configurable read latency;
  - a misalignment error response.
- Keeps the board-side set port for editing contents from switches.
- Sits in the MEM stage; the pipeline stalls on `req_ready`/`rsp_valid`.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_hs_if.sv | 31 +++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_hs.sv | 148 ++++++++++++++
 tb/tb_dmem_hs.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked MIPS data memory.
// Used by dmem_hs, dmem_lane_align and the bench.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RESP
    } state_e;

    localparam logic [31:0] INIT_W0 = 32'd126;
    localparam logic [31:0] INIT_W1 = 32'd127;

endpackage

// File: rtl/dmem_hs_if.sv
// Request/response bus between the MEM stage and dmem_hs.
// The master issues requests; the slave is the memory.
interface dmem_hs_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_size,
        output req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size,
        input  req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_hs: store enables/replicated data,
// load extraction with extension, and the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  wsize,
    input  logic [1:0]  wlane,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wshift,
    output logic        bad,
    input  logic [1:0]  rsize,
    input  logic [1:0]  rlane,
    input  logic        rsigned,
    input  logic [31:0] rword,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be     = 4'b0000;
        wshift = wdata;
        bad    = 1'b0;
        case (size_e'(wsize))
            SZ_BYTE: begin
                be     = 4'b0001 << wlane;
                wshift = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be     = wlane[1] ? 4'b1100 : 4'b0011;
                wshift = {2{wdata[15:0]}};
                bad    = wlane[0];
            end
            SZ_WORD: begin
                be  = 4'b1111;
                bad = |wlane;
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        rbyte = rword[{rlane, 3'b000} +: 8];
        rhalf = rlane[1] ? rword[31:16] : rword[15:0];
        case (size_e'(rsize))
            SZ_BYTE: rdata = {{24{rsigned & rbyte[7]}}, rbyte};
            SZ_HALF: rdata = {{16{rsigned & rhalf[15]}}, rhalf};
            default: rdata = rword;
        endcase
    end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked MEM-stage data memory with board set port.
// Define DMEM_OOR_ERR_EN to reject addresses beyond DEPTH words.
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int SET_VAL_WIDTH = 3,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    dmem_hs_if.slave                 bus,
    input  logic                     set_en,
    input  logic [IW-1:0]            set_idx,
    input  logic [SET_VAL_WIDTH-1:0] set_val,
    output logic                     set_ack
);

    state_e                state;
    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0] ldIdx;
    logic [1:0]    ldLane;
    logic [1:0]    ldSize;
    logic          ldSigned;

    logic [IW-1:0]         reqIdx;
    logic [1:0]            reqLane;
    logic [ADDR_WIDTH-1:0] hiBits;
    logic                  accept;
    logic                  misalign;
    logic                  oor;
    logic                  reqBad;

    logic [IW-1:0]         rIdx;
    logic [1:0]            rLane;
    logic [1:0]            rSize;
    logic                  rSigned;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wshift;
    logic [DATA_WIDTH-1:0] ext;

    assign reqIdx  = bus.req_addr[2 +: IW];
    assign reqLane = bus.req_addr[1:0];
    assign hiBits  = bus.req_addr >> (IW + 2);

`ifdef DMEM_OOR_ERR_EN
    assign oor = |hiBits;
`else
    logic unusedHi;
    assign unusedHi = |hiBits;
    assign oor      = 1'b0;
`endif

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid & bus.req_ready;
    assign reqBad        = misalign | oor;

    // Latency-1 loads read on the accept edge, so use the live request.
    assign rIdx    = (state == IDLE) ? reqIdx         : ldIdx;
    assign rLane   = (state == IDLE) ? reqLane        : ldLane;
    assign rSize   = (state == IDLE) ? bus.req_size   : ldSize;
    assign rSigned = (state == IDLE) ? bus.req_signed : ldSigned;

    assign set_ack = set_en & ~rst & (state == IDLE) & ~bus.req_valid;

    dmem_lane_align u_align (
        .wsize   (bus.req_size),
        .wlane   (reqLane),
        .wdata   (bus.req_wdata),
        .be      (be),
        .wshift  (wshift),
        .bad     (misalign),
        .rsize   (rSize),
        .rlane   (rLane),
        .rsigned (rSigned),
        .rword   (mem[rIdx]),
        .rdata   (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ldIdx         <= '0;
            ldLane        <= '0;
            ldSize        <= '0;
            ldSigned      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            mem[0] <= INIT_W0;
            mem[1] <= INIT_W1;
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ldIdx         <= reqIdx;
                        ldLane        <= reqLane;
                        ldSize        <= bus.req_size;
                        ldSigned      <= bus.req_signed;
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        if (reqBad) begin
                            bus.rsp_err <= 1'b1;
                        end else if (bus.req_write) begin
                            for (int i = 0; i < 4; i++) begin
                                if (be[i]) begin
                                    mem[reqIdx][8*i +: 8] <= wshift[8*i +: 8];
                                end
                            end
                        end else if (READ_LATENCY == 1) begin
                            bus.rsp_rdata <= ext;
                        end else begin
                            state         <= RWAIT;
                            bus.rsp_valid <= 1'b0;
                            cnt           <= 2'(READ_LATENCY - 1);
                        end
                    end else if (set_en) begin
                        mem[set_idx] <= DATA_WIDTH'(set_val);
                    end
                end
                RWAIT: begin
                    if (cnt == 2'd1) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= ext;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: two instances (latency 3 and 1), vector table,
// hand sequences and random traffic against a byte-array model.
module tb_dmem_hs;
    import dmem_pkg::*;

    localparam int L3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel;
    logic        reqValid;
    logic        reqWrite;
    logic        reqSigned;
    logic [1:0]  reqSize;
    logic [7:0]  reqAddr;
    logic [31:0] reqWdata;
    logic        setEn;
    logic [3:0]  setIdx;
    logic [2:0]  setVal;
    logic        ack3;
    logic        ack1;

    dmem_hs_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b3 ();
    dmem_hs_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b1 ();

    assign b3.req_valid  = reqValid & ~sel;
    assign b3.req_write  = reqWrite;
    assign b3.req_size   = reqSize;
    assign b3.req_signed = reqSigned;
    assign b3.req_addr   = reqAddr;
    assign b3.req_wdata  = reqWdata;
    assign b1.req_valid  = reqValid & sel;
    assign b1.req_write  = reqWrite;
    assign b1.req_size   = reqSize;
    assign b1.req_signed = reqSigned;
    assign b1.req_addr   = reqAddr;
    assign b1.req_wdata  = reqWdata;

    dmem_hs #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(8),
        .READ_LATENCY(L3), .SET_VAL_WIDTH(3)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave),
        .set_en(setEn & ~sel), .set_idx(setIdx),
        .set_val(setVal), .set_ack(ack3)
    );

    dmem_hs #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(8),
        .READ_LATENCY(1), .SET_VAL_WIDTH(3)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave),
        .set_en(setEn & sel), .set_idx(setIdx),
        .set_val(setVal), .set_ack(ack1)
    );

    typedef struct {
        logic        s;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [7:0]  a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    int nCmp = 0;
    int nBad = 0;

    logic [7:0] mb [2][64];

    function automatic logic rdy();
        return sel ? b1.req_ready : b3.req_ready;
    endfunction
    function automatic logic rv();
        return sel ? b1.rsp_valid : b3.rsp_valid;
    endfunction
    function automatic logic rerr();
        return sel ? b1.rsp_err : b3.rsp_err;
    endfunction
    function automatic logic [31:0] rrd();
        return sel ? b1.rsp_rdata : b3.rsp_rdata;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic mdlReset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) mb[d][i] = 8'd0;
            mb[d][0] = 8'd126;
            mb[d][4] = 8'd127;
        end
    endtask

    task automatic mdlSet(input int d, input int idx, input int val);
        mb[d][4*idx]   = 8'(val);
        mb[d][4*idx+1] = 8'd0;
        mb[d][4*idx+2] = 8'd0;
        mb[d][4*idx+3] = 8'd0;
    endtask

    // Memory as 64 bytes, little endian; requests as byte runs.
    task automatic mdlXact(inout vec_t v);
        int n;
        int a;
        logic [63:0] x;
        a = int'(v.a) % 64;
        n = 1 << v.sz;
        v.err = (v.sz == 2'd3) || ((int'(v.a) % n) != 0);
`ifdef DMEM_OOR_ERR_EN
        if (v.a >= 8'd64) v.err = 1'b1;
`endif
        v.rd  = 32'd0;
        v.lat = (v.err || v.w) ? 1 : (v.s ? 1 : L3);
        x = 64'd0;
        if (!v.err) begin
            if (v.w) begin
                for (int k = 0; k < n; k++) mb[v.s][a+k] = v.wd[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++)
                    x = x | (64'(mb[v.s][a+k]) << (8*k));
                if (v.sg && n < 4 && x[8*n-1])
                    x = x | ({64{1'b1}} << (8*n));
                v.rd = x[31:0];
            end
        end
    endtask

    task automatic xact(input vec_t v, output logic e,
                        output logic [31:0] r, output int lat);
        int g;
        @(negedge clk);
        sel       = v.s;
        reqWrite  = v.w;
        reqSize   = v.sz;
        reqSigned = v.sg;
        reqAddr   = v.a;
        reqWdata  = v.wd;
        reqValid  = 1'b1;
        g = 0;
        while (!rdy() && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("ready_timeout", 32'(rdy()), 32'd1);
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0;
        e   = 1'b0;
        r   = 32'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rv()) begin
                lat = c;
                break;
            end
            chk("ready_wait", 32'(rdy()), 32'd0);
        end
        if (lat != 0) begin
            e = rerr();
            r = rrd();
            chk("ready_resp", 32'(rdy()), 32'd0);
            @(negedge clk);
            chk("rsp_pulse", 32'(rv()), 32'd0);
            chk("ready_after", 32'(rdy()), 32'd1);
        end
    endtask

    task automatic apply(input string nm, input vec_t v);
        logic e;
        logic [31:0] r;
        int l;
        xact(v, e, r, l);
        chk({nm, "_err"}, 32'(e), 32'(v.err));
        chk({nm, "_rdata"}, r, v.rd);
        chk({nm, "_lat"}, 32'(l), 32'(v.lat));
    endtask

    task automatic runModel(input string nm, input vec_t v);
        mdlXact(v);
        apply(nm, v);
    endtask

    task automatic doSet(input logic s, input int idx, input int val);
        @(negedge clk);
        sel    = s;
        setIdx = 4'(idx);
        setVal = 3'(val);
        setEn  = 1'b1;
        #1 chk("set_ack", 32'(s ? ack1 : ack3), 32'd1);
        @(posedge clk);
        #1 setEn = 1'b0;
        mdlSet(int'(s), idx, val);
    endtask

    vec_t tbl[$];
    vec_t v;
    vec_t sink;
    int   acc[$];
    int   rsp[$];
    int   nrv;
    logic [1:0] m;

    initial begin
        sel = 1'b0; reqValid = 1'b0; reqWrite = 1'b0;
        reqSigned = 1'b0; reqSize = 2'd0; reqAddr = 8'd0;
        reqWdata = 32'd0; setEn = 1'b0; setIdx = 4'd0; setVal = 3'd0;
        mdlReset();

        //            s  w  sz sg addr   wdata         err rdata        lat
        tbl.push_back('{1, 0, 2, 0, 8'h00, 32'h0,        0, 32'd126,      1});
        tbl.push_back('{1, 0, 2, 0, 8'h04, 32'h0,        0, 32'd127,      1});
        tbl.push_back('{1, 0, 2, 0, 8'h08, 32'h0,        0, 32'd0,        1});
        tbl.push_back('{1, 1, 2, 0, 8'h0C, 32'hAABBCCDD, 0, 32'd0,        1});
        tbl.push_back('{1, 0, 0, 1, 8'h0E, 32'h0,        0, 32'hFFFFFFBB, 1});
        tbl.push_back('{1, 0, 1, 0, 8'h0C, 32'h0,        0, 32'h0000CCDD, 1});
        tbl.push_back('{1, 1, 1, 0, 8'h11, 32'h1234,     1, 32'd0,        1});
        tbl.push_back('{1, 0, 2, 0, 8'h10, 32'h0,        0, 32'd0,        1});
        tbl.push_back('{1, 0, 3, 0, 8'h00, 32'h0,        1, 32'd0,        1});
        tbl.push_back('{1, 0, 1, 1, 8'h0E, 32'h0,        0, 32'hFFFFAABB, 1});
`ifdef DMEM_OOR_ERR_EN
        tbl.push_back('{1, 1, 0, 0, 8'h41, 32'h7F,       1, 32'd0,        1});
        tbl.push_back('{1, 0, 2, 0, 8'h00, 32'h0,        0, 32'd126,      1});
`else
        tbl.push_back('{1, 1, 0, 0, 8'h41, 32'h7F,       0, 32'd0,        1});
        tbl.push_back('{1, 0, 2, 0, 8'h00, 32'h0,        0, 32'h00007F7E, 1});
`endif
        tbl.push_back('{0, 0, 2, 0, 8'h04, 32'h0,        0, 32'd127,      3});
        tbl.push_back('{0, 0, 2, 0, 8'h00, 32'h0,        0, 32'd126,      3});
        tbl.push_back('{0, 1, 2, 0, 8'h08, 32'h80000001, 0, 32'd0,        1});
        tbl.push_back('{0, 0, 0, 1, 8'h0B, 32'h0,        0, 32'hFFFFFF80, 3});
        tbl.push_back('{0, 0, 1, 0, 8'h03, 32'h0,        1, 32'd0,        1});
        tbl.push_back('{0, 0, 0, 0, 8'h08, 32'h0,        0, 32'h00000001, 3});

        #12;
        chk("rst_rsp_valid3", 32'(b3.rsp_valid), 32'd0);
        chk("rst_rsp_valid1", 32'(b1.rsp_valid), 32'd0);
        chk("rst_rsp_err1", 32'(b1.rsp_err), 32'd0);
        chk("rst_rdata1", b1.rsp_rdata, 32'd0);
        chk("rst_ready3", 32'(b3.req_ready), 32'd1);
        chk("rst_ready1", 32'(b1.req_ready), 32'd1);
        chk("rst_set_ack1", 32'(ack1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            sink = tbl[i];
            mdlXact(sink);
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Held req_valid on the latency-3 instance.
        @(negedge clk);
        sel = 1'b0; reqWrite = 1'b0; reqSize = 2'd2;
        reqSigned = 1'b0; reqAddr = 8'h04; reqValid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (b3.req_ready) acc.push_back(c);
            if (b3.rsp_valid) begin
                rsp.push_back(c);
                chk("held_rdata", b3.rsp_rdata, 32'd127);
            end
            @(negedge clk);
        end
        reqValid = 1'b0;
        chk("held_accepts", 32'(acc.size()), 32'd3);
        chk("held_rsps", 32'(rsp.size()), 32'd3);
        if (acc.size() >= 2 && rsp.size() >= 2) begin
            chk("held_spacing", 32'(acc[1] - acc[0]), 32'd4);
            chk("held_lat0", 32'(rsp[0] - acc[0]), 32'd3);
            chk("held_lat1", 32'(rsp[1] - acc[1]), 32'd3);
        end

        // Set port collides with an accepted store: the bus wins.
        @(negedge clk);
        sel = 1'b1; reqWrite = 1'b1; reqSize = 2'd2; reqAddr = 8'h08;
        reqWdata = 32'hDEAD0000; reqValid = 1'b1;
        setEn = 1'b1; setIdx = 4'd2; setVal = 3'd5;
        #1 chk("set_ack_conflict", 32'(ack1), 32'd0);
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        chk("set_ack_resp", 32'(ack1), 32'd0);
        chk("store_rsp_valid", 32'(b1.rsp_valid), 32'd1);
        @(negedge clk);
        chk("set_ack_idle", 32'(ack1), 32'd1);
        @(posedge clk);
        #1 setEn = 1'b0;
        sink = '{1, 1, 2, 0, 8'h08, 32'hDEAD0000, 0, 0, 0};
        mdlXact(sink);
        mdlSet(1, 2, 5);
        apply("set_load", '{1, 0, 2, 0, 8'h08, 32'h0, 0, 32'd5, 1});

        // Reset during RWAIT abandons the load and reinitialises memory.
        runModel("pre_rst_store", '{0, 1, 2, 0, 8'h00, 32'h11111111, 0, 0, 0});
        @(negedge clk);
        sel = 1'b0; reqWrite = 1'b0; reqSize = 2'd2; reqAddr = 8'h00;
        reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        chk("rwait_ready", 32'(b3.req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nrv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b3.rsp_valid) nrv++;
        end
        chk("rst_no_rsp", 32'(nrv), 32'd0);
        mdlReset();
        apply("post_rst3", '{0, 0, 2, 0, 8'h00, 32'h0, 0, 32'd126, 3});
        apply("post_rst1", '{1, 0, 2, 0, 8'h00, 32'h0, 0, 32'd126, 1});
        runModel("oor_load", '{1, 0, 2, 0, 8'h40, 32'h0, 0, 0, 0});

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                doSet(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                      $urandom_range(0, 7));
            end
            v.s  = 1'($urandom_range(0, 1));
            v.w  = 1'($urandom_range(0, 1));
            v.sz = ($urandom_range(0, 7) == 0) ? 2'd3 :
                   2'($urandom_range(0, 2));
            v.sg = 1'($urandom_range(0, 1));
            v.a  = 8'($urandom);
            v.wd = $urandom;
            m = (v.sz == 2'd1) ? 2'b01 : (v.sz == 2'd2) ? 2'b11 : 2'b00;
            if ($urandom_range(0, 3) != 0) v.a[1:0] = v.a[1:0] & ~m;
            if ($urandom_range(0, 3) != 0) v.a[7:6] = 2'b00;
            runModel($sformatf("rnd%0d", i), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
